float_to_unsint: RTL and testbench

//  Converts an IEEE-754 single-precision value to a 32-bit unsigned integer, truncating toward zero.

---
 rtl/fpu_pkg.sv | 27 ++
 rtl/fp32_classify.sv | 33 +++
 rtl/float_to_unsint.sv | 134 +++++++++++++
 tb/tb_float_to_unsint.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU converter definitions: FSM state encodings and fp32 field layout.
// Used by the float/unsigned-int converters in the execute path.
package fpu_pkg;

   typedef enum logic [2:0] {
      GET_A  = 3'd0,
      UNPACK = 3'd1,
      ALIGN  = 3'd2,
      PACK   = 3'd3,
      PUT_Z  = 3'd4
   } fpu_state_t;

   localparam int FP32_EXP_BIAS = 127;
   localparam int FP32_EXP_MAX  = 255;

   localparam int FP32_SIGN   = 31;
   localparam int FP32_EXP_HI = 30;
   localparam int FP32_EXP_LO = 23;
   localparam int FP32_MAN_HI = 22;
   localparam int FP32_MAN_LO = 0;

   // Mantissa with the hidden one restored, left-justified in a 32-bit word.
   function automatic logic [31:0] fp32_msb_aligned(input logic [22:0] man);
      return {1'b1, man, 8'b0};
   endfunction

endpackage

// File: rtl/fp32_classify.sv
// Combinational fp32 operand classifier: special-value flags, sign and unbiased exponent.
module fp32_classify
   import fpu_pkg::*;
(
   input  logic [31:0]       a,
   output logic              is_nan,
   output logic              is_inf,
   output logic              is_zero,
   output logic              is_denorm,
   output logic              sign,
   output logic signed [8:0] exp_unb
);

   logic [7:0]  ex;
   logic [22:0] man;
   logic        ex_max;
   logic        ex_min;

   assign ex     = a[FP32_EXP_HI:FP32_EXP_LO];
   assign man    = a[FP32_MAN_HI:FP32_MAN_LO];
   assign sign   = a[FP32_SIGN];
   assign ex_max = (ex == 8'(FP32_EXP_MAX));
   assign ex_min = (ex == 8'd0);

   assign is_nan    = ex_max && (man != '0);
   assign is_inf    = ex_max && (man == '0);
   assign is_zero   = ex_min && (man == '0);
   assign is_denorm = ex_min && (man != '0);

   // Zero-extended before subtracting so the result is a true signed 9-bit exponent.
   assign exp_unb = $signed({1'b0, ex}) - $signed(9'(FP32_EXP_BIAS));

endmodule

// File: rtl/float_to_unsint.sv
// fp32 -> 32-bit unsigned integer converter, truncating toward zero.
// Multi-cycle FSM with a one-bit-per-cycle right shifter; en/complete handshake.
module float_to_unsint
   import fpu_pkg::*;
#(
   parameter logic [31:0] OVF_VALUE = 32'hFFFF_FFFF,
   parameter logic [31:0] NAN_VALUE = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [31:0] input_a,
   output logic [31:0] output_z,
   output logic        complete,
   output logic        invalid
);

   fpu_state_t state;

   logic [31:0] a;
   logic [31:0] val;
   logic [4:0]  cnt;
   logic [31:0] res;
   logic        inv;
   logic [31:0] z;
   logic        zi;

   logic              is_nan;
   logic              is_inf;
   logic              is_zero;
   logic              is_denorm;
   logic              sign;
   logic signed [8:0] exp_unb;

   logic        unp_special;
   logic [31:0] unp_res;
   logic        unp_inv;

   fp32_classify u_classify (
      .a         (a),
      .is_nan    (is_nan),
      .is_inf    (is_inf),
      .is_zero   (is_zero),
      .is_denorm (is_denorm),
      .sign      (sign),
      .exp_unb   (exp_unb)
   );

   // Special cases resolve straight to a forced result; only in-range values are shifted.
   always_comb begin
      unp_special = 1'b1;
      unp_res     = '0;
      unp_inv     = 1'b1;
      if (is_nan) begin
         unp_res = NAN_VALUE;
      end else if (sign && !is_zero) begin
         unp_res = '0;
      end else if (is_inf || (exp_unb >= 9'sd32)) begin
         unp_res = OVF_VALUE;
      end else if (is_zero || is_denorm || (exp_unb < 9'sd0)) begin
         unp_inv = 1'b0;
      end else begin
         unp_special = 1'b0;
         unp_inv     = 1'b0;
      end
   end

   // Control: state and the externally visible outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= GET_A;
         output_z <= '0;
         complete <= 1'b0;
         invalid  <= 1'b0;
      end else if (!en) begin
         output_z <= '0;
         complete <= 1'b0;
         invalid  <= 1'b0;
      end else begin
         case (state)
            GET_A: begin
               complete <= 1'b0;
               state    <= UNPACK;
            end
            UNPACK: state <= unp_special ? PACK : ALIGN;
            ALIGN: begin
               if (cnt == 5'd31) state <= PACK;
            end
            PACK: state <= PUT_Z;
            PUT_Z: begin
               output_z <= z;
               invalid  <= zi;
               complete <= 1'b1;
               state    <= GET_A;
            end
            default: state <= GET_A;
         endcase
      end
   end

   // Datapath: no reset needed, every register is written before it is consumed.
   always_ff @(posedge clk) begin
      if (en) begin
         case (state)
            GET_A: a <= input_a;
            UNPACK: begin
               if (unp_special) begin
                  res <= unp_res;
                  inv <= unp_inv;
               end else begin
                  val <= fp32_msb_aligned(a[FP32_MAN_HI:FP32_MAN_LO]);
                  cnt <= exp_unb[4:0];
               end
            end
            ALIGN: begin
               // Bits shifted out are dropped: plain truncation toward zero.
               if (cnt == 5'd31) begin
                  res <= val;
                  inv <= 1'b0;
               end else begin
                  val <= val >> 1;
                  cnt <= cnt + 5'd1;
               end
            end
            PACK: begin
               z  <= res;
               zi <= inv;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_float_to_unsint.sv
// Directed self-checking bench for float_to_unsint.
module tb_float_to_unsint;

   logic        clk;
   logic        rst;
   logic        en;
   logic [31:0] input_a;
   logic [31:0] output_z;
   logic        complete;
   logic        invalid;

   int vectors;
   int miscompares;

   float_to_unsint dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .input_a  (input_a),
      .output_z (output_z),
      .complete (complete),
      .invalid  (invalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called #1 after an edge with the FSM in GET_A. lat counts edges from capture to complete;
   // lat==100 means no completion arrived. held reports output_z stayed put until completion.
   task automatic run_conv(input logic [31:0] v, output logic [31:0] z, output logic zi,
                           output int lat, output bit held);
      logic [31:0] prev;
      prev    = output_z;
      held    = 1'b1;
      input_a = v;
      @(posedge clk);
      #1;
      input_a = ~v;
      lat = 0;
      while (lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         if (complete) break;
         if (output_z !== prev) held = 1'b0;
      end
      z  = output_z;
      zi = invalid;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en  = 1'b1;
      input_a = 32'h3F80_0000;
      repeat (3) @(posedge clk);
      #1;
      vectors++; if (output_z !== 32'h0) begin miscompares++; $display("FAIL reset_z got %h want 00000000", output_z); end
      vectors++; if (complete !== 1'b0) begin miscompares++; $display("FAIL reset_complete got %b want 0", complete); end
      vectors++; if (invalid !== 1'b0) begin miscompares++; $display("FAIL reset_invalid got %b want 0", invalid); end
      rst = 1'b0;
   endtask

   task automatic test_one();
      logic [31:0] z; logic zi; int lat; bit held;
      run_conv(32'h3F80_0000, z, zi, lat, held);
      vectors++; if (z !== 32'h0000_0001) begin miscompares++; $display("FAIL one_z got %h want 00000001", z); end
      vectors++; if (zi !== 1'b0) begin miscompares++; $display("FAIL one_inv got %b want 0", zi); end
      vectors++; if (lat !== 35) begin miscompares++; $display("FAIL one_latency got %0d want 35", lat); end
   endtask

   task automatic test_truncation();
      logic [31:0] z; logic zi; int lat; bit held;
      run_conv(32'h4020_0000, z, zi, lat, held);
      vectors++; if (z !== 32'h0000_0002) begin miscompares++; $display("FAIL trunc_2p5_z got %h want 00000002", z); end
      vectors++; if (zi !== 1'b0) begin miscompares++; $display("FAIL trunc_2p5_inv got %b want 0", zi); end
      vectors++; if (lat !== 34) begin miscompares++; $display("FAIL trunc_2p5_latency got %0d want 34", lat); end
      run_conv(32'h3F7F_FFFF, z, zi, lat, held);
      vectors++; if (z !== 32'h0) begin miscompares++; $display("FAIL below_one_z got %h want 00000000", z); end
      vectors++; if (zi !== 1'b0) begin miscompares++; $display("FAIL below_one_inv got %b want 0", zi); end
      vectors++; if (lat >= 100) begin miscompares++; $display("FAIL below_one_timeout got %0d edges want <100", lat); end
   endtask

   task automatic test_max_range();
      logic [31:0] z; logic zi; int lat; bit held;
      run_conv(32'h4F7F_FFFF, z, zi, lat, held);
      vectors++; if (z !== 32'hFFFF_FF00) begin miscompares++; $display("FAIL max_z got %h want ffffff00", z); end
      vectors++; if (zi !== 1'b0) begin miscompares++; $display("FAIL max_inv got %b want 0", zi); end
      vectors++; if (lat !== 4) begin miscompares++; $display("FAIL max_latency got %0d want 4", lat); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] z; logic zi; int lat; bit held;
      // Previous result ffffff00 must remain visible throughout this conversion.
      run_conv(32'h4020_0000, z, zi, lat, held);
      vectors++; if (held !== 1'b1) begin miscompares++; $display("FAIL hold_between got changed want held"); end
      vectors++; if (z !== 32'h0000_0002) begin miscompares++; $display("FAIL b2b_z got %h want 00000002", z); end
   endtask

   task automatic test_overflow();
      logic [31:0] z; logic zi; int lat; bit held;
      run_conv(32'h4F80_0000, z, zi, lat, held);
      vectors++; if (z !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL ovf_2p32_z got %h want ffffffff", z); end
      vectors++; if (zi !== 1'b1) begin miscompares++; $display("FAIL ovf_2p32_inv got %b want 1", zi); end
      run_conv(32'h7F80_0000, z, zi, lat, held);
      vectors++; if (z !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL ovf_inf_z got %h want ffffffff", z); end
      vectors++; if (zi !== 1'b1) begin miscompares++; $display("FAIL ovf_inf_inv got %b want 1", zi); end
   endtask

   task automatic test_negative();
      logic [31:0] z; logic zi; int lat; bit held;
      run_conv(32'hBF80_0000, z, zi, lat, held);
      vectors++; if (z !== 32'h0) begin miscompares++; $display("FAIL neg_one_z got %h want 00000000", z); end
      vectors++; if (zi !== 1'b1) begin miscompares++; $display("FAIL neg_one_inv got %b want 1", zi); end
      run_conv(32'h8000_0000, z, zi, lat, held);
      vectors++; if (z !== 32'h0) begin miscompares++; $display("FAIL neg_zero_z got %h want 00000000", z); end
      vectors++; if (zi !== 1'b0) begin miscompares++; $display("FAIL neg_zero_inv got %b want 0", zi); end
      run_conv(32'hFF80_0000, z, zi, lat, held);
      vectors++; if (z !== 32'h0) begin miscompares++; $display("FAIL neg_inf_z got %h want 00000000", z); end
      vectors++; if (zi !== 1'b1) begin miscompares++; $display("FAIL neg_inf_inv got %b want 1", zi); end
   endtask

   task automatic test_nan();
      logic [31:0] z; logic zi; int lat; bit held;
      run_conv(32'h4F7F_FFFF, z, zi, lat, held);
      run_conv(32'h7FC0_0000, z, zi, lat, held);
      vectors++; if (z !== 32'h0) begin miscompares++; $display("FAIL nan_z got %h want 00000000", z); end
      vectors++; if (zi !== 1'b1) begin miscompares++; $display("FAIL nan_inv got %b want 1", zi); end
      vectors++; if (lat >= 100) begin miscompares++; $display("FAIL nan_timeout got %0d edges want <100", lat); end
   endtask

   task automatic test_rst_mid();
      logic [31:0] z; logic zi; int lat; bit held;
      run_conv(32'h7F80_0000, z, zi, lat, held);
      input_a = 32'h3F80_0000;
      @(posedge clk);
      #1;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      vectors++; if (output_z !== 32'h0) begin miscompares++; $display("FAIL rst_mid_z got %h want 00000000", output_z); end
      vectors++; if (invalid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_inv got %b want 0", invalid); end
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (complete !== 1'b0) begin miscompares++; $display("FAIL rst_mid_complete got %b want 0", complete); end
      rst = 1'b0;
      run_conv(32'h4020_0000, z, zi, lat, held);
      vectors++; if (z !== 32'h0000_0002) begin miscompares++; $display("FAIL rst_after_z got %h want 00000002", z); end
      vectors++; if (lat !== 34) begin miscompares++; $display("FAIL rst_after_latency got %0d want 34", lat); end
   endtask

   task automatic test_en_pause();
      logic [31:0] z; logic zi; int lat; bit held;
      int pulses;
      int seen_at;
      logic [31:0] res;
      run_conv(32'h4F7F_FFFF, z, zi, lat, held);
      input_a = 32'h3F80_0000;
      @(posedge clk);
      #1;
      input_a = 32'h0;
      pulses  = 0;
      seen_at = 0;
      res     = '0;
      for (int n = 1; n <= 39; n++) begin
         @(posedge clk);
         #1;
         if (complete) begin
            pulses++;
            seen_at = n;
            res     = output_z;
         end
         if (n == 11 || n == 13) begin
            vectors++; if (output_z !== 32'h0) begin miscompares++; $display("FAIL pause_z edge %0d got %h want 00000000", n, output_z); end
            vectors++; if (complete !== 1'b0) begin miscompares++; $display("FAIL pause_complete edge %0d got %b want 0", n, complete); end
         end
         if (n == 10) en = 1'b0;
         if (n == 13) en = 1'b1;
      end
      vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL pause_pulses got %0d want 1", pulses); end
      vectors++; if (seen_at !== 38) begin miscompares++; $display("FAIL pause_latency got %0d want 38", seen_at); end
      vectors++; if (res !== 32'h0000_0001) begin miscompares++; $display("FAIL pause_z_result got %h want 00000001", res); end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      en          = 1'b1;
      input_a     = '0;
      test_reset();
      do_reset();
      test_one();
      test_truncation();
      test_max_range();
      test_back_to_back();
      test_overflow();
      test_negative();
      test_nan();
      test_rst_mid();
      test_en_pause();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
